// File: rtl/sysmgr_reboot.sv
// Warm-boot sequencer: an arm strobe opens a short window in which a reboot request is accepted,
// then reset is held for a drain period before the SB_WARMBOOT BOOT strobe is raised.
module sysmgr_reboot #(
  parameter int unsigned ARM_W = 8,
  parameter int unsigned DLY_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arm_stb,
  input  logic       req_stb,
  input  logic [1:0] req_sel,
  output logic       rst_req,
  output logic [1:0] boot_sel,
  output logic       boot,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StArmed, StDrain, StBoot} state_e;

  state_e             state_q;
  logic [ARM_W-1:0]   arm_cnt_q;
  logic [DLY_W-1:0]   dly_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      arm_cnt_q <= '0;
      dly_cnt_q <= '0;
      rst_req   <= 1'b0;
      boot_sel  <= 2'b00;
      boot      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // A request without a prior arm is deliberately ignored.
          if (arm_stb) begin
            state_q   <= StArmed;
            arm_cnt_q <= '0;
            busy      <= 1'b1;
          end
        end
        StArmed: begin
          // Priority: request, then re-arm, then window timeout.
          if (req_stb) begin
            state_q   <= StDrain;
            boot_sel  <= req_sel;
            dly_cnt_q <= '0;
            rst_req   <= 1'b1;
          end else if (arm_stb) begin
            arm_cnt_q <= '0;
          end else if (arm_cnt_q == '1) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end else begin
            arm_cnt_q <= arm_cnt_q + ARM_W'(1);
          end
        end
        StDrain: begin
          if (dly_cnt_q == '1) begin
            state_q <= StBoot;
            boot    <= 1'b1;
          end else begin
            dly_cnt_q <= dly_cnt_q + DLY_W'(1);
          end
        end
        StBoot: begin
          // Terminal: only reset leaves this state.
          boot <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sysmgr_reboot.sv
// Bench for sysmgr_reboot with a 3-bit arm window and 4-bit drain delay.
module tb_sysmgr_reboot;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       arm_stb;
  logic       req_stb;
  logic [1:0] req_sel;
  logic       rst_req;
  logic [1:0] boot_sel;
  logic       boot;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  // {busy, rst_req, boot, boot_sel} expected for the cycle after each driven edge
  logic [4:0] exp_q[$];

  sysmgr_reboot #(.ARM_W(3), .DLY_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .arm_stb  (arm_stb),
    .req_stb  (req_stb),
    .req_sel  (req_sel),
    .rst_req  (rst_req),
    .boot_sel (boot_sel),
    .boot     (boot),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick(input logic a, input logic r, input logic [1:0] s, input logic n);
    arm_stb = a;
    req_stb = r;
    req_sel = s;
    rst_n   = n;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    tick(1'b0, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic test_reset();
    logic [4:0] exp, obs;
    for (int k = 0; k < 4; k++) begin
      // Strobes during reset must not be remembered once reset releases.
      exp_q.push_back(5'b0);
      if (k < 2) tick(1'b1, 1'b1, 2'b11, 1'b0);
      else       tick(1'b0, 1'b0, 2'b00, 1'b1);
      obs = {busy, rst_req, boot, boot_sel};
      exp = exp_q.pop_front();
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL reset k=%0d: got %b want %b", k, obs, exp);
      end
    end
  endtask

  task automatic test_main();
    logic [4:0] exp, obs;
    int c;
    apply_reset();
    for (int k = 0; k < 30; k++) begin
      c = k + 1;
      if (k < 26) begin
        exp = {1'b1, c >= 4, c >= 20, (c >= 4) ? 2'b10 : 2'b00};
        exp_q.push_back(exp);
        tick(k == 0, k == 3 || k == 10, (k == 3) ? 2'b10 : 2'b01, 1'b1);
      end else begin
        // Reset while in BOOT, then stay quiet: no residual boot.
        exp_q.push_back(5'b0);
        tick(1'b0, 1'b0, 2'b00, k != 26);
      end
      obs = {busy, rst_req, boot, boot_sel};
      exp = exp_q.pop_front();
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL main k=%0d: got %b want %b", k, obs, exp);
      end
    end
  endtask

  task automatic test_no_arm();
    logic [4:0] exp, obs;
    apply_reset();
    for (int k = 0; k < 50; k++) begin
      exp_q.push_back(5'b0);
      tick(1'b0, (k % 3) == 0, 2'(k), 1'b1);
      obs = {busy, rst_req, boot, boot_sel};
      exp = exp_q.pop_front();
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL no_arm k=%0d: got %b want %b", k, obs, exp);
      end
    end
  endtask

  task automatic test_timeout();
    logic [4:0] exp, obs;
    int c;
    apply_reset();
    for (int k = 0; k < 16; k++) begin
      c = k + 1;
      exp = {c >= 1 && c <= 8, 1'b0, 1'b0, 2'b00};
      exp_q.push_back(exp);
      tick(k == 0, k == 9, 2'b11, 1'b1);
      obs = {busy, rst_req, boot, boot_sel};
      exp = exp_q.pop_front();
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL timeout k=%0d: got %b want %b", k, obs, exp);
      end
    end
  endtask

  task automatic test_rearm();
    logic [4:0] exp, obs;
    int c;
    apply_reset();
    for (int k = 0; k < 32; k++) begin
      c = k + 1;
      exp = {1'b1, c >= 13, c >= 29, (c >= 13) ? 2'b01 : 2'b00};
      exp_q.push_back(exp);
      // After acceptance, keep toggling strobes and select to prove they are ignored.
      if (k <= 12) tick(k == 0 || k == 6, k == 12, (k == 12) ? 2'b01 : 2'b10, 1'b1);
      else         tick(k[0], ~k[0], 2'(k), 1'b1);
      obs = {busy, rst_req, boot, boot_sel};
      exp = exp_q.pop_front();
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL rearm k=%0d: got %b want %b", k, obs, exp);
      end
    end
  endtask

  task automatic test_reset_drain();
    logic [4:0] exp, obs;
    int c;
    apply_reset();
    for (int k = 0; k < 40; k++) begin
      c = k + 1;
      if (k < 12) exp = {1'b1, c >= 2, 1'b0, (c >= 2) ? 2'b11 : 2'b00};
      else        exp = 5'b0;
      exp_q.push_back(exp);
      tick(k == 0, k == 1, 2'b11, k != 12);
      obs = {busy, rst_req, boot, boot_sel};
      exp = exp_q.pop_front();
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL reset_drain k=%0d: got %b want %b", k, obs, exp);
      end
    end
  endtask

  task automatic test_same_cycle();
    logic [4:0] exp, obs;
    int c;
    apply_reset();
    for (int k = 0; k < 22; k++) begin
      c = k + 1;
      exp = {1'b1, c >= 3, c >= 19, (c >= 3) ? 2'b01 : 2'b00};
      exp_q.push_back(exp);
      tick(k == 0, k == 0 || k == 2, (k == 0) ? 2'b11 : 2'b01, 1'b1);
      obs = {busy, rst_req, boot, boot_sel};
      exp = exp_q.pop_front();
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL same_cycle k=%0d: got %b want %b", k, obs, exp);
      end
    end
  endtask

  // Request landing on the last cycle of the arm window must still be taken.
  task automatic test_req_at_window_end();
    logic [4:0] exp, obs;
    int c;
    apply_reset();
    for (int k = 0; k < 28; k++) begin
      c = k + 1;
      exp = {1'b1, c >= 9, c >= 25, (c >= 9) ? 2'b11 : 2'b00};
      exp_q.push_back(exp);
      tick(k == 0, k == 8, (k == 8) ? 2'b11 : 2'b00, 1'b1);
      obs = {busy, rst_req, boot, boot_sel};
      exp = exp_q.pop_front();
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL window_end k=%0d: got %b want %b", k, obs, exp);
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    arm_stb = 1'b0;
    req_stb = 1'b0;
    req_sel = 2'b00;
    test_reset();
    test_main();
    test_no_arm();
    test_timeout();
    test_rearm();
    test_reset_drain();
    test_same_cycle();
    test_req_at_window_end();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sysmgr_reboot.md
SYSMGR_REBOOT -- requirements
Module: sysmgr_reboot

Interface
REQ-001 SHALL have parameter ARM_W, default 8, meaning arm window length of 2^ARM_W clk cycles.
REQ-002 SHALL have parameter DLY_W, default 16, meaning reset-drain delay of 2^DLY_W clk cycles before boot.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port arm_stb  input  1  one-cycle strobe that opens the arm window.
REQ-006 SHALL have port req_stb  input  1  one-cycle reboot request strobe.
REQ-007 SHALL have port req_sel  input  2  boot image index sampled with req_stb.
REQ-008 SHALL have port rst_req  output  1  active-high reset request to the clock/reset manager's rst_in.
REQ-009 SHALL have port boot_sel  output  2  image select to SB_WARMBOOT S1:S0.
REQ-010 SHALL have port boot  output  1  SB_WARMBOOT BOOT strobe.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, ARMED, DRAIN, BOOT, all registered.
REQ-013 IDLE: arm_stb=1 -> ARMED, arm counter cleared to 0; req_stb alone SHALL be ignored.
REQ-014 ARMED: arm counter (ARM_W bits) SHALL increment each cycle; req_stb=1 -> DRAIN, latch req_sel into boot_sel, clear delay counter.
REQ-015 ARMED: counter at all-ones without req_stb -> IDLE (timeout); req_stb in that same cycle SHALL win (-> DRAIN).
REQ-016 ARMED: arm_stb=1 without req_stb SHALL restart the arm counter at 0, state unchanged.
REQ-017 Same-cycle arm_stb and req_stb in IDLE -> ARMED only; request not honoured.
REQ-018 DRAIN: rst_req=1; delay counter (DLY_W bits) increments each cycle; at all-ones -> BOOT next cycle.
REQ-019 DRAIN and BOOT SHALL ignore arm_stb, req_stb, req_sel; boot_sel SHALL stay frozen.
REQ-020 BOOT: rst_req=1 and boot=1, held until rst_n; no exit transition.
REQ-021 rst_req SHALL go high the cycle after the accepted req_stb; boot SHALL go high exactly 2^DLY_W cycles after rst_req rises.
REQ-022 All outputs SHALL be registered; no combinational path input -> output.
REQ-023 Counters SHALL saturate-compare at all-ones, never wrap to 0 while counting.

Reset
REQ-024 rst_n=0 at any clk edge SHALL force IDLE, counters 0, rst_req=0, boot=0, boot_sel=2'b00, busy=0 on the next cycle.
REQ-025 Reset mid-DRAIN or in BOOT SHALL abort the sequence; no residual boot pulse after rst_n returns high.
REQ-026 Inputs sampled in the cycle rst_n=0 SHALL have no effect.

Verification (ARM_W=3, DLY_W=4)
REQ-027 arm_stb at t0, req_stb+req_sel=2'b10 at t0+3 -> rst_req=1 at t0+4, boot_sel=2'b10, boot=1 at t0+20, held.
REQ-028 req_stb with no prior arm_stb -> busy, rst_req, boot stay 0 for 50 cycles.
REQ-029 arm_stb at t0, no req -> busy=1 for 8 cycles then IDLE; req_stb at t0+9 ignored.
REQ-030 arm_stb at t0 and t0+6, req_stb at t0+12 -> accepted (window restarted); req_sel change during DRAIN leaves boot_sel unchanged.
REQ-031 rst_n=0 for 1 cycle at t0+10 of DRAIN -> all outputs 0 next cycle, boot never asserted afterward.
REQ-032 Same-cycle arm_stb+req_stb in IDLE -> ARMED, rst_req stays 0; later req_stb accepted normally.
